proc_param: RTL and testbench
=============================

Name: proc_param

Overview:
- Parametrised next-generation multicycle bus processor: NREGS general registers, accumulator A, result register G and a single shared bus, all DATA_W wide.
- One instruction is fetched from DIN per Run handshake and executed in 2–4 timesteps, with Done signalling completion.
- Adds a logical AND, a conditional move, a zero flag, register reset and a Run-qualified fetch.
- Sits where the fixed 9-bit processor sat; it is driven by the same DIN/Run source, such as an instruction ROM or counter.

Parameters:
- DATA_W, 9, datapath, bus, register and DIN width; must be ≥ 3 + 2*RBITS.
- NREGS, 8, number of general registers; must be a power of 2 and ≥ 2. RBITS = log2(NREGS).

Ports:
- Clock  in  1  rising-edge clock
- Resetn  in  1  asynchronous active-low reset
- DIN  in  DATA_W  instruction word in T0; immediate data in T1 for mvi
- Run  in  1  start request, sampled in T0
- Done  out  1  combinational; high during the final timestep of an instruction
- BusWires  out  DATA_W  shared bus value; 0 when no source is selected
- Zero  out  1  registered; 1 when G == 0

Behaviour:
- Instruction fields, right-aligned in IR; upper unused bits are ignored:
  - op = IR[2*RBITS+2 : 2*RBITS]
  - X = IR[2*RBITS-1 : RBITS]
  - Y = IR[RBITS-1 : 0]
- Reset: timestep = T0, all registers R0..Rn-1 = 0, A = 0, G = 0, IR = 0, Zero = 1, Done = 0.
- FSM states T0–T3:
  - T0: if Run is high, IR <= DIN and go to T1; otherwise stay in T0 with IR unchanged.
  - From T1 or T2: if Done is high, go to T0; otherwise advance to the next timestep.
  - T3 always goes to T0.
- Opcodes, with the per-timestep actions:
  - 000 mv: T1 bus = Ry, Rx <= bus, Done.
  - 001 mvi: T1 bus = DIN, Rx <= bus, Done. The immediate is presented on DIN during T1.
  - 010 add: T1 A <= Rx; T2 G <= A + Ry; T3 bus = G, Rx <= bus, Done.
  - 011 sub: same as add with G <= A - Ry.
  - 100 cnt1: T1 bus = Rx, G <= popcount(bus), zero-extended; T2 bus = G, Ry <= bus, Done.
  - 101 and: same as add with G <= A & Ry.
  - 110 mvnz: see Optional Feature.
  - 111 nop: T1 Done, no register writes, bus = 0.
- Arithmetic wraps modulo 2^DATA_W. There is no carry output.
- Zero <= (new G value == 0) on every clock edge on which G is loaded. Zero is otherwise held.
- Bus source priority: exactly one source is selected per timestep by construction. The bus is 0 in T0 and in any timestep with no selected source.
- X == Y is legal:
  - add Rx,Rx gives 2*Rx.
  - mv Rx,Rx leaves Rx unchanged.
  - cnt1 Rx,Rx overwrites Rx with its own count.
- Run is ignored outside T0. Run held high gives back-to-back instructions with no idle cycle between them.
- Reset asserted mid-instruction aborts the instruction immediately: state returns to T0 and all register state is cleared, with no partial write-back.
- Done is never high in T0.

Optional Feature:
- Macro PROC_MVNZ_EN.
- Defined: op 110 mvnz: T1 bus = Ry; if Zero == 0 then Rx <= bus. Done in T1.
- Undefined: op 110 behaves exactly as nop: Done in T1, no writes.

Decomposition:
- Package proc_pkg contains:
  - opcode localparams OP_MV … OP_NOP
  - timestep localparams T0–T3
  - a clog2 function
  - a helper computing field positions from RBITS
- One sub-module, popcount_n, parameterised by DATA_W: a combinational count of ones, width clog2(DATA_W+1).
- The register file, A, G and IR are instantiated from the existing regn-style register, extended with an asynchronous clear.

Test Plan (defaults DATA_W=9, NREGS=8 unless stated):
- Reset: pulse Resetn low mid-add at T2. Expect state T0, every register = 0, Zero = 1, Done = 0 and bus = 0 on the next cycle.
- mvi R0,5 with Run held high, then mvi R1,3, then add R0,R1:
  - expect R0 = 8 and Done high only in T1, T1, T3 respectively;
  - expect no idle cycle between instructions.
- sub R2,R3 with R2 = 0 and R3 = 1: expect R2 = 9'h1FF (wrap) and Zero = 0. Then and R2,R4 with R4 = 0: expect G = 0 and Zero = 1.
- cnt1 R5,R6 with R5 = 9'b101101101: expect R6 = 6 after T2 and Done in T2.
- mvnz R7,R1 with and without PROC_MVNZ_EN:
  - Macro defined, Zero = 0: R7 <= R1.
  - Macro defined, Zero = 1: R7 unchanged.
  - Macro undefined: R7 unchanged in both cases.
- Run low for 5 cycles with DIN toggling: expect IR unchanged, state T0 and no register writes. Then set DATA_W=16, NREGS=16 and repeat the mvi/add sequence with 4-bit X and Y fields: expect the correct result.

Source files
------------

// File: rtl/proc_param_pkg.sv
// Shared definitions for proc_param: opcodes, timesteps, bus sources and
// instruction field-position helpers.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_CNT1 = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_REG  = 2'd1,
    SEL_DIN  = 2'd2,
    SEL_G    = 2'd3
  } bus_sel_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Fields are right-aligned: {op, X, Y} with X and Y each rbits wide.
  function automatic int op_lsb(input int rbits);
    return 2 * rbits;
  endfunction

  function automatic int x_lsb(input int rbits);
    return rbits;
  endfunction

endpackage

// File: rtl/proc_param_popcount.sv
// Combinational count of ones across a DATA_W-wide word.
module popcount_n import proc_pkg::*; #(
  parameter int DATA_W = 9,
  parameter int CNT_W  = clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [CNT_W-1:0]  o_count
);

  // Ripple sum of the individual bits.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < DATA_W; i++) begin
      o_count = o_count + CNT_W'(i_data[i]);
    end
  end

endmodule

// File: rtl/proc_param_regn.sv
// Load-enabled register with asynchronous active-low clear; used for the
// register file, A, G and IR.
module regn #(
  parameter int W = 9
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Holding register: clear on reset, load when enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/proc_param.sv
// proc_param: parametrised multicycle single-bus processor with NREGS general
// registers, accumulator A and result G. Macro PROC_MVNZ_EN enables op 110 (mvnz).
module proc_param import proc_pkg::*; #(
  parameter int DATA_W = 9,
  parameter int NREGS  = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [DATA_W-1:0] DIN,
  input  logic              Run,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires,
  output logic              Zero
);

  localparam int RBITS = clog2(NREGS);
  localparam int OP_L  = op_lsb(RBITS);
  localparam int X_L   = x_lsb(RBITS);
  localparam int CNT_W = clog2(DATA_W + 1);

  tstep_e            r_step;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_g;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic              r_zero;

  logic [2:0]        w_op;
  logic [RBITS-1:0]  w_x;
  logic [RBITS-1:0]  w_y;
  logic [RBITS-1:0]  w_ridx;
  bus_sel_e          w_sel;
  logic [NREGS-1:0]  w_rin;
  logic              w_ain;
  logic              w_gin;
  logic              w_irin;
  logic              w_done;
  logic [DATA_W-1:0] w_gd;
  logic [CNT_W-1:0]  w_cnt;

  assign w_op   = r_ir[OP_L+2:OP_L];
  assign w_x    = r_ir[OP_L-1:X_L];
  assign w_y    = r_ir[RBITS-1:0];
  assign w_irin = (r_step == T0) && Run;

  regn #(.W(DATA_W)) u_ir (.i_clk(Clock), .i_rst_n(Resetn), .i_en(w_irin), .i_d(DIN),      .o_q(r_ir));
  regn #(.W(DATA_W)) u_a  (.i_clk(Clock), .i_rst_n(Resetn), .i_en(w_ain),  .i_d(BusWires), .o_q(r_a));
  regn #(.W(DATA_W)) u_g  (.i_clk(Clock), .i_rst_n(Resetn), .i_en(w_gin),  .i_d(w_gd),     .o_q(r_g));

  for (genvar i = 0; i < NREGS; i++) begin : g_rf
    regn #(.W(DATA_W)) u_r (
      .i_clk  (Clock),
      .i_rst_n(Resetn),
      .i_en   (w_rin[i]),
      .i_d    (BusWires),
      .o_q    (r_regs[i])
    );
  end

  popcount_n #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_pop (.i_data(BusWires), .o_count(w_cnt));

  // Per-timestep control decode; exactly one bus source at most.
  always_comb begin
    w_sel  = SEL_NONE;
    w_ridx = '0;
    w_rin  = '0;
    w_ain  = 1'b0;
    w_gin  = 1'b0;
    w_done = 1'b0;
    case (r_step)
      T1: begin
        case (w_op)
          OP_MV: begin
            w_sel      = SEL_REG;
            w_ridx     = w_y;
            w_rin[w_x] = 1'b1;
            w_done     = 1'b1;
          end
          OP_MVI: begin
            w_sel      = SEL_DIN;
            w_rin[w_x] = 1'b1;
            w_done     = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            w_sel  = SEL_REG;
            w_ridx = w_x;
            w_ain  = 1'b1;
          end
          OP_CNT1: begin
            w_sel  = SEL_REG;
            w_ridx = w_x;
            w_gin  = 1'b1;
          end
`ifdef PROC_MVNZ_EN
          OP_MVNZ: begin
            w_sel      = SEL_REG;
            w_ridx     = w_y;
            w_rin[w_x] = ~r_zero;
            w_done     = 1'b1;
          end
`endif
          default: begin
            w_done = 1'b1;
          end
        endcase
      end
      T2: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_AND: begin
            w_sel  = SEL_REG;
            w_ridx = w_y;
            w_gin  = 1'b1;
          end
          OP_CNT1: begin
            w_sel      = SEL_G;
            w_rin[w_y] = 1'b1;
            w_done     = 1'b1;
          end
          default: begin
            w_done = 1'b0;
          end
        endcase
      end
      T3: begin
        w_sel      = SEL_G;
        w_rin[w_x] = 1'b1;
        w_done     = 1'b1;
      end
      default: begin
        w_sel = SEL_NONE;
      end
    endcase
  end

  // Shared bus multiplexer.
  always_comb begin
    case (w_sel)
      SEL_REG: BusWires = r_regs[w_ridx];
      SEL_DIN: BusWires = DIN;
      SEL_G:   BusWires = r_g;
      default: BusWires = '0;
    endcase
  end

  // Value loaded into G for the current operation.
  always_comb begin
    case (w_op)
      OP_ADD:  w_gd = r_a + BusWires;
      OP_SUB:  w_gd = r_a - BusWires;
      OP_AND:  w_gd = r_a & BusWires;
      OP_CNT1: w_gd = DATA_W'(w_cnt);
      default: w_gd = '0;
    endcase
  end

  // Timestep sequencer.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_step <= T0;
    end else begin
      case (r_step)
        T0:      r_step <= Run ? T1 : T0;
        T1:      r_step <= w_done ? T0 : T2;
        T2:      r_step <= w_done ? T0 : T3;
        default: r_step <= T0;
      endcase
    end
  end

  // Zero tracks G only on the edges that load it.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_zero <= 1'b1;
    end else if (w_gin) begin
      r_zero <= (w_gd == '0);
    end else begin
      r_zero <= r_zero;
    end
  end

  assign Done = w_done;
  assign Zero = r_zero;

endmodule

// File: tb/tb_proc_param.sv
// Randomised scoreboard bench for proc_param, run on two configurations
// (9-bit/8 regs and 16-bit/16 regs) side by side.
module tb_proc_param;

  localparam logic [2:0] MV = 3'b000, MVI = 3'b001, ADD = 3'b010, SUB = 3'b011;
  localparam logic [2:0] CNT = 3'b100, AND = 3'b101, MVNZ = 3'b110, NOP = 3'b111;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_pass = 0;
  bit cfg_done [2];

  task automatic check(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL cfg%0d %s: got %0h, expected %0h", c, nm, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int DW = (g == 0) ? 9 : 16;
    localparam int NR = (g == 0) ? 8 : 16;
    localparam int RB = (g == 0) ? 3 : 4;

    logic          rst_n;
    logic [DW-1:0] din;
    logic          run;
    logic          done;
    logic [DW-1:0] bus;
    logic          zero;

    proc_param #(.DATA_W(DW), .NREGS(NR)) dut (
      .Clock   (Clock),
      .Resetn  (rst_n),
      .DIN     (din),
      .Run     (run),
      .Done    (done),
      .BusWires(bus),
      .Zero    (zero)
    );

    // Reference state: architectural registers and the zero flag.
    logic [DW-1:0] mreg [NR];
    logic          mzero;
    logic [DW-1:0] q_bus [$];
    bit            q_zero [$];
    int            q_len [$];

    function automatic logic [DW-1:0] enc(input logic [2:0] op, input int x, input int y);
      logic [DW-1:0] w;
      w = DW'($urandom);
      w[2*RB+2:2*RB] = op;
      w[2*RB-1:RB]   = RB'(x);
      w[RB-1:0]      = RB'(y);
      return w;
    endfunction

    task automatic issue(input logic [2:0] op, input int x, input int y, input logic [DW-1:0] imm);
      logic [DW-1:0] eb, gv;
      int len;
      eb = '0;
      gv = '0;
      len = 2;
      case (op)
        MV:  begin eb = mreg[y]; mreg[x] = eb; end
        MVI: begin eb = imm; mreg[x] = imm; end
        ADD, SUB, AND: begin
          if (op == ADD)      gv = mreg[x] + mreg[y];
          else if (op == SUB) gv = mreg[x] - mreg[y];
          else                gv = mreg[x] & mreg[y];
          mzero = (gv == 0);
          mreg[x] = gv;
          eb = gv;
          len = 4;
        end
        CNT: begin
          gv = DW'($countones(mreg[x]));
          mzero = (gv == 0);
          mreg[y] = gv;
          eb = gv;
          len = 3;
        end
        MVNZ: begin
`ifdef PROC_MVNZ_EN
          eb = mreg[y];
          if (!mzero) mreg[x] = eb;
`else
          eb = '0;
`endif
        end
        default: eb = '0;
      endcase
      q_bus.push_back(eb);
      q_zero.push_back(mzero);
      q_len.push_back(len);
      din = enc(op, x, y);
      run = 1'b1;
      @(posedge Clock); #1;
      din = imm;
      repeat (len - 1) begin
        @(posedge Clock); #1;
      end
    endtask

    task automatic read_all();
      for (int i = 0; i < NR; i++) issue(MV, i, i, '0);
    endtask

    // Monitor: pop and compare on every Done, also checking instruction length.
    initial begin : mon
      int cyc;
      logic [DW-1:0] eb;
      bit ez;
      int el;
      cyc = 0;
      forever begin
        @(negedge Clock);
        if (!rst_n) begin
          cyc = 0;
        end else if (done) begin
          if (q_len.size() == 0) begin
            check("spurious done", g, q_len.size(), 1);
          end else begin
            eb = q_bus.pop_front();
            ez = q_zero.pop_front();
            el = q_len.pop_front();
            check("bus", g, bus, eb);
            check("zero", g, zero, ez);
            check("length", g, cyc + 1, el);
          end
          cyc = 0;
        end else if (run) begin
          cyc++;
          if (cyc > 4) begin
            check("done timeout", g, cyc, 4);
            cyc = 0;
          end
        end else begin
          cyc = 0;
        end
      end
    end

    initial begin : stim
      rst_n = 1'b0;
      run   = 1'b0;
      din   = '0;
      mzero = 1'b1;
      for (int i = 0; i < NR; i++) mreg[i] = '0;
      repeat (2) @(posedge Clock);
      #1;
      check("reset done", g, done, 0);
      check("reset bus", g, bus, 0);
      check("reset zero", g, zero, 1);
      rst_n = 1'b1;

      // Back-to-back mvi/mvi/add, then wrap, and-to-zero, popcount, mvnz.
      issue(MVI, 0, 0, DW'(5));
      issue(MVI, 1, 0, DW'(3));
      issue(ADD, 0, 1, '0);
      issue(MVI, 2, 0, '0);
      issue(MVI, 3, 0, DW'(1));
      issue(SUB, 2, 3, '0);
      issue(MVI, 4, 0, '0);
      issue(AND, 2, 4, '0);
      issue(MVI, 5, 0, DW'(9'b101101101));
      issue(CNT, 5, 6, '0);
      issue(MVI, 7, 0, DW'(11));
      issue(MVNZ, 7, 1, '0);
      issue(MV, 7, 7, '0);
      issue(MVI, 7, 0, DW'(12));
      issue(AND, 2, 4, '0);
      issue(MVNZ, 7, 1, '0);
      issue(MV, 7, 7, '0);
      issue(ADD, 1, 1, '0);
      issue(CNT, 3, 3, '0);

      // Reset in T2 of an add.
      din = enc(ADD, 0, 1);
      run = 1'b1;
      @(posedge Clock); #1;
      din = '0;
      @(posedge Clock); #1;
      run   = 1'b0;
      rst_n = 1'b0;
      #1;
      check("abort done", g, done, 0);
      check("abort bus", g, bus, 0);
      check("abort zero", g, zero, 1);
      for (int i = 0; i < NR; i++) mreg[i] = '0;
      mzero = 1'b1;
      @(posedge Clock); #1;
      rst_n = 1'b1;
      check("post-reset done", g, done, 0);
      check("post-reset bus", g, bus, 0);
      read_all();

      // Idle with DIN toggling: nothing may happen.
      issue(MVI, 2, 0, DW'(77));
      run = 1'b0;
      for (int i = 0; i < 5; i++) begin
        din = DW'($urandom);
        @(posedge Clock); #1;
        check("idle done", g, done, 0);
        check("idle bus", g, bus, 0);
      end
      read_all();

      // Random instruction stream with occasional idle gaps.
      for (int n = 0; n < 200; n++) begin
        issue(3'($urandom_range(0, 7)), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1), DW'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          run = 1'b0;
          din = DW'($urandom);
          repeat ($urandom_range(1, 3)) begin
            @(posedge Clock); #1;
          end
        end
      end
      read_all();
      run = 1'b0;
      repeat (6) @(posedge Clock);
      #1;
      check("scoreboard drained", g, q_len.size(), 0);
      cfg_done[g] = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    wait (cfg_done[0] && cfg_done[1]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
